// File: rtl/reset_logic_delay_line_param.sv
// Parametrised WIDTH x DEPTH delay line with stall, synchronous flush, per-stage taps and fill tracking.
// Optional runtime tap select is built only when RESET_DELAY_LINE_TAP_SEL_EN is defined.
module reset_logic_delay_line_param #(
  parameter int                 WIDTH     = 1,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                TSW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int                FCW       = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [TSW-1:0]           tap_sel,
  output logic [WIDTH*DEPTH-1:0]   data_taps,
  output logic [WIDTH-1:0]         data_out,
  output logic [WIDTH-1:0]         data_tap,
  output logic [FCW-1:0]           fill_count,
  output logic                     primed
);

  localparam logic [FCW-1:0] FILL_MAX = FCW'(DEPTH);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [FCW-1:0]   r_fill_count;
  logic [WIDTH-1:0] w_tap;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= RESET_VAL;
      end
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_stage[k] <= RESET_VAL;
      end
    end else if (enable) begin
      r_stage[0] <= data_in;
      for (int k = 1; k < DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  // Fill count saturates so primed stays asserted until the next reset or flush.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_fill_count <= '0;
    end else if (flush) begin
      r_fill_count <= '0;
    end else if (enable && (r_fill_count != FILL_MAX)) begin
      r_fill_count <= r_fill_count + 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_taps
      assign data_taps[(g+1)*WIDTH-1 -: WIDTH] = r_stage[g];
    end
  endgenerate

`ifdef RESET_DELAY_LINE_TAP_SEL_EN
  // Out-of-range selects fall through to the last stage.
  always_comb begin
    w_tap = r_stage[DEPTH-1];
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(tap_sel) == k) begin
        w_tap = r_stage[k];
      end
    end
  end
`else
  logic w_unused_tap_sel;
  assign w_unused_tap_sel = ^tap_sel;
  assign w_tap            = r_stage[DEPTH-1];
`endif

  assign data_out   = r_stage[DEPTH-1];
  assign data_tap   = w_tap;
  assign fill_count = r_fill_count;
  assign primed     = (r_fill_count == FILL_MAX);

endmodule

// File: tb/tb_reset_logic_delay_line_param.sv
// Scoreboard bench for reset_logic_delay_line_param (WIDTH=8, DEPTH=4) against a history-queue model.
module tb_reset_logic_delay_line_param;

  localparam int W = 8;
  localparam int D = 4;

  logic           clock;
  logic           resetn;
  logic           enable;
  logic           flush;
  logic [W-1:0]   data_in;
  logic [1:0]     tap_sel;
  logic [W*D-1:0] data_taps;
  logic [W-1:0]   data_out;
  logic [W-1:0]   data_tap;
  logic [2:0]     fill_count;
  logic           primed;

  reset_logic_delay_line_param #(.WIDTH(W), .DEPTH(D), .RESET_VAL(8'h00)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .flush(flush),
    .data_in(data_in), .tap_sel(tap_sel), .data_taps(data_taps),
    .data_out(data_out), .data_tap(data_tap), .fill_count(fill_count), .primed(primed)
  );

  typedef struct {
    logic [W*D-1:0] taps;
    logic [W-1:0]   out;
    logic [W-1:0]   tap;
    logic [2:0]     fill;
    logic           primed;
    string          tag;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int errors = 0;

  // Reference model: most recent enabled inputs, newest first, plus total enabled shifts.
  logic [W-1:0] hist[$];
  int           shifts = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] modelStage(int k);
    if (k <= hist.size()) return hist[k-1];
    return 8'h00;
  endfunction

  function automatic exp_t makeExp(string tag);
    exp_t e;
    int sel;
    for (int k = 1; k <= D; k++) e.taps[k*W-1 -: W] = modelStage(k);
    e.out = modelStage(D);
`ifdef RESET_DELAY_LINE_TAP_SEL_EN
    sel = (int'(tap_sel) >= D) ? D : int'(tap_sel) + 1;
`else
    sel = D;
`endif
    e.tap    = modelStage(sel);
    e.fill   = 3'((shifts > D) ? D : shifts);
    e.primed = (shifts >= D);
    e.tag    = tag;
    return e;
  endfunction

  task automatic modelReset();
    hist.delete();
    shifts = 0;
  endtask

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every falling edge, compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.tag, " data_taps"},  data_taps,          e.taps);
        checkOutput({e.tag, " data_out"},   {24'h0, data_out},  {24'h0, e.out});
        checkOutput({e.tag, " data_tap"},   {24'h0, data_tap},  {24'h0, e.tap});
        checkOutput({e.tag, " fill_count"}, {29'h0, fill_count},{29'h0, e.fill});
        checkOutput({e.tag, " primed"},     {31'h0, primed},    {31'h0, e.primed});
      end
    end
  end

  // One clock step: drive inputs away from the edge, update the model at the edge,
  // optionally pull resetn low just after the edge, then queue the expectation.
  task automatic applyStimulus(input logic en, input logic fl, input logic [W-1:0] din,
                               input logic [1:0] ts, input logic midReset, input string tag);
    enable  = en;
    flush   = fl;
    data_in = din;
    tap_sel = ts;
    @(posedge clock);
    if (!resetn || fl) begin
      modelReset();
    end else if (en) begin
      hist.push_front(din);
      if (hist.size() > D) void'(hist.pop_back());
      shifts++;
    end
    #1;
    if (midReset) begin
      resetn = 1'b0;
      modelReset();
    end
    #1;
    expQ.push_back(makeExp(tag));
    @(negedge clock);
    #1;
  endtask

  initial begin
    logic [W-1:0] seq [4];
    int waitCycles;
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    resetn = 1'b0; enable = 1'b0; flush = 1'b0; data_in = '0; tap_sel = '0;
    #1;
    expQ.push_back(makeExp("reset"));
    @(negedge clock);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, seq[i], 2'd0, 1'b0, "fill");
    applyStimulus(1'b0, 1'b0, 8'h5A, 2'd0, 1'b0, "tapsel0");
    applyStimulus(1'b0, 1'b0, 8'h5A, 2'd2, 1'b0, "tapsel2");
    applyStimulus(1'b0, 1'b0, 8'h5A, 2'd3, 1'b0, "tapsel3");
    applyStimulus(1'b0, 1'b0, 8'h5A, 2'd1, 1'b1, "midreset");
    resetn = 1'b1;

    applyStimulus(1'b1, 1'b0, 8'h01, 2'd1, 1'b0, "stall");
    applyStimulus(1'b1, 1'b0, 8'h02, 2'd1, 1'b0, "stall");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'hEE, 2'd0, 1'b0, "stallhold");
    applyStimulus(1'b1, 1'b0, 8'h03, 2'd2, 1'b0, "stallresume");

    applyStimulus(1'b1, 1'b1, 8'hAA, 2'd0, 1'b0, "flush");
    applyStimulus(1'b0, 1'b0, 8'hAA, 2'd3, 1'b0, "postflush");

    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'(8'h60 + i), 2'd3, 1'b0, "saturate");

    for (int i = 0; i < 300; i++) begin
      logic midRst;
      midRst = ($urandom_range(0, 49) == 0);
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                    8'($urandom), 2'($urandom), midRst, "random");
      if (midRst) resetn = 1'b1;
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(negedge clock);
      waitCycles++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
